// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: req/ready handshake, fixed wait states,
// 1K x 32 word array with byte-enable stores.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Elaboration-time legality checks on the configuration
    generate
        if (WAIT_CYCLES > 15) begin : g_bad_wait
            $error("dmem_responder: WAIT_CYCLES must be in 0..15");
        end
        if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
            $error("dmem_responder: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ready_d, busy_d;
    logic [DATA_W-1:0]   rdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Next-state, request latch and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        rdata_d = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    be_d    = be;
                    wdata_d = wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are computed one cycle early so they leave straight from flops
        ready_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
        if ((state_d == S_RESP) && !we_d) begin
            rdata_d = mem[addr_d];
        end
    end

    // State, request and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ready   <= ready_d;
            busy    <= busy_d;
            rdata   <= rdata_d;
        end
    end

    // Store commit at the edge that ends RESP; a reset on that edge cancels it
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_RESP) && we_q) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 2, 3 wait states) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_dmem_responder;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;
    localparam int          NI     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [3:0]        be = '0;
    logic [31:0]       wdata = '0;
    logic              ready_o [NI];
    logic              busy_o  [NI];
    logic [31:0]       rdata_o [NI];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .ready(ready_o[0]), .rdata(rdata_o[0]), .busy(busy_o[0]));
    dmem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .ready(ready_o[1]), .rdata(rdata_o[1]), .busy(busy_o[1]));
    dmem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .ready(ready_o[2]), .rdata(rdata_o[2]), .busy(busy_o[2]));

    function automatic int wc(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    // Transaction-level model: one pending request per instance, answered at a
    // precomputed cycle; the word image is updated when that cycle ends.
    longint            cyc = 0;
    bit                m_pend  [NI];
    longint            m_tresp [NI];
    bit                m_we    [NI];
    bit [ADDR_W-1:0]   m_addr  [NI];
    bit [3:0]          m_be    [NI];
    bit [31:0]         m_wdata [NI];
    bit [31:0]         m_mem   [NI][DEPTH];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_pend[k] = 1'b0;
            end else if (m_pend[k] && cyc == m_tresp[k]) begin
                if (m_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[k][b]) m_mem[k][m_addr[k]][8*b +: 8] = m_wdata[k][8*b +: 8];
                end
                m_pend[k] = 1'b0;
            end else if (!m_pend[k] && req) begin
                m_pend[k]  = 1'b1;
                m_tresp[k] = cyc + longint'(wc(k)) + 1;
                m_we[k]    = we;
                m_addr[k]  = addr;
                m_be[k]    = be;
                m_wdata[k] = wdata;
            end
        end
        cyc = cyc + 1;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    int          n_ready      [NI];
    logic [31:0] last_rdata   [NI];
    longint      last_rdy_cyc [NI];

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%08h required=%08h", name, k, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of every instance against the model
    task automatic cmp_cycle();
        bit          e_rdy;
        bit [31:0]   e_rd;
        if (!chk_en) return;
        for (int k = 0; k < NI; k++) begin
            e_rdy = m_pend[k] && (cyc == m_tresp[k]);
            e_rd  = (e_rdy && !m_we[k]) ? m_mem[k][m_addr[k]] : 32'h0;
            check("busy",  k, 32'(busy_o[k]),  32'(m_pend[k]));
            check("ready", k, 32'(ready_o[k]), 32'(e_rdy));
            check("rdata", k, rdata_o[k], e_rd);
            if (ready_o[k] === 1'b1) begin
                n_ready[k]++;
                last_rdata[k]   = rdata_o[k];
                last_rdy_cyc[k] = cyc;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit any_busy();
        return (busy_o[0] === 1'b1) || (busy_o[1] === 1'b1) || (busy_o[2] === 1'b1);
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (!any_busy()) break;
            step();
        end
        check("idle_wait", -1, 32'(any_busy()), 32'h0);
    endtask

    task automatic txn(input logic w, input logic [ADDR_W-1:0] a, input logic [3:0] b,
                       input logic [31:0] d, output longint acc);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        acc = cyc;
        step();
        req = 1'b0; we = 1'($urandom); addr = ADDR_W'($urandom); be = 4'($urandom); wdata = $urandom;
        wait_idle();
    endtask

    longint acc;
    int     snap [NI];

    initial begin
        for (int k = 0; k < NI; k++) begin
            n_ready[k] = 0; last_rdata[k] = '0; last_rdy_cyc[k] = 0;
        end
        // Reset held two cycles, then five idle cycles
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("no_ready_after_reset", 1, 32'(n_ready[1]), 32'd0);

        // Bring the whole array to a known zero image
        for (int a = 0; a < DEPTH; a++) txn(1'b1, ADDR_W'(a), 4'hF, 32'h0, acc);

        // Store then load, with acceptance-to-ready latency
        txn(1'b1, 10'h004, 4'hF, 32'hDEADBEEF, acc);
        check("store_lat_w0", 0, 32'(last_rdy_cyc[0] - acc), 32'd1);
        check("store_lat_w2", 1, 32'(last_rdy_cyc[1] - acc), 32'd3);
        check("store_lat_w3", 2, 32'(last_rdy_cyc[2] - acc), 32'd4);
        check("store_rdata_zero", 1, last_rdata[1], 32'h0);
        txn(1'b0, 10'h004, 4'h0, 32'h0, acc);
        check("load_lat_w2", 1, 32'(last_rdy_cyc[1] - acc), 32'd3);
        check("load_data_w2", 1, last_rdata[1], 32'hDEADBEEF);

        // Byte-enable merge, and an all-disabled store leaving the word intact
        txn(1'b1, 10'h010, 4'hF, 32'h11223344, acc);
        txn(1'b1, 10'h010, 4'b0101, 32'hAABBCCDD, acc);
        txn(1'b0, 10'h010, 4'h0, 32'h0, acc);
        for (int k = 0; k < NI; k++) check("be_merge", k, last_rdata[k], 32'h11BB33DD);
        txn(1'b1, 10'h010, 4'b0000, 32'hFFFFFFFF, acc);
        txn(1'b0, 10'h010, 4'h0, 32'h0, acc);
        check("be_none", 0, last_rdata[0], 32'h11BB33DD);

        // req held high for ten cycles: each instance re-accepts only from IDLE
        for (int k = 0; k < NI; k++) snap[k] = n_ready[k];
        for (int i = 0; i < 10; i++) begin
            req = 1'b1; we = 1'b0; addr = 10'h004; be = 4'h0; wdata = 32'h0;
            step();
        end
        req = 1'b0;
        wait_idle();
        check("held_req_w0", 0, 32'(n_ready[0] - snap[0]), 32'd5);
        check("held_req_w2", 1, 32'(n_ready[1] - snap[1]), 32'd3);
        check("held_req_w3", 2, 32'(n_ready[2] - snap[2]), 32'd2);
        check("held_req_data", 0, last_rdata[0], 32'hDEADBEEF);

        // Reset on the edge entering RESP of the 3-wait instance: no pulse, no write
        for (int k = 0; k < NI; k++) snap[k] = n_ready[k];
        req = 1'b1; we = 1'b1; addr = 10'h020; be = 4'hF; wdata = 32'h12345678;
        step();
        req = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle();
        check("rst_wait_no_ready", 2, 32'(n_ready[2] - snap[2]), 32'd0);
        txn(1'b0, 10'h020, 4'h0, 32'h0, acc);
        check("rst_wait_mem_w3", 2, last_rdata[2], 32'h0);
        check("rst_wait_mem_w0", 0, last_rdata[0], 32'h12345678);

        // Reset during the RESP cycle itself: commit suppressed
        for (int k = 0; k < NI; k++) snap[k] = n_ready[k];
        req = 1'b1; we = 1'b1; addr = 10'h024; be = 4'hF; wdata = 32'h12345678;
        step();
        req = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle();
        check("rst_resp_pulse", 2, 32'(n_ready[2] - snap[2]), 32'd1);
        txn(1'b0, 10'h024, 4'h0, 32'h0, acc);
        check("rst_resp_mem_w3", 2, last_rdata[2], 32'h0);
        check("rst_resp_mem_w2", 1, last_rdata[1], 32'h12345678);

        // Top and bottom of the address range
        txn(1'b1, 10'h3FF, 4'hF, 32'hCAFEF00D, acc);
        txn(1'b0, 10'h3FF, 4'h0, 32'h0, acc);
        check("addr_top", 1, last_rdata[1], 32'hCAFEF00D);
        txn(1'b0, 10'h000, 4'h0, 32'h0, acc);
        check("addr_bottom", 1, last_rdata[1], 32'h0);

        // Random traffic with occasional resets, checked cycle by cycle
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(127) == 0);
            req   = 1'($urandom);
            we    = 1'($urandom);
            addr  = ($urandom_range(1) == 0) ? ADDR_W'($urandom_range(15)) : ADDR_W'($urandom);
            be    = 4'($urandom);
            wdata = $urandom;
            step();
        end
        rst = 1'b0;
        req = 1'b0;
        wait_idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
